// File: rtl/sram_port_arbiter.sv
// Purpose: shares one multi-cycle single-port SRAM between instruction fetch and the MEM stage.
// Latency: a request seen in IDLE at cycle T gets its one-cycle ready pulse at T+WAIT_CYCLES+1.
// Backpressure: requesters hold their request and are frozen (if_freeze/mem_freeze) until ready.
//
// Optional feature macro: ARB_FAIR_EN. When defined, conflicts alternate between the ports using a
// last-grant register that resets to IF. When undefined, MEM always beats IF.
//
// Ports:
//   clock, reset                      system clock, synchronous active-high reset
//   if_req/if_addr                    fetch request and byte address (held until if_ready)
//   if_rdata/if_ready                 fetched word and its completion pulse
//   mem_rd_en/mem_wr_en               load/store request (both high = store)
//   mem_addr/mem_wdata                load/store byte address and store data
//   mem_rdata/mem_ready               load data and its completion pulse
//   if_freeze/mem_freeze              pipeline holds while an access is outstanding
//   sram_addr                         SRAM word address (byte address [ADDR_W+1:2])
//   sram_dq_out/sram_dq_oe/sram_dq_in SRAM data pads: write data, output enable, read data
//   sram_we_n                         active-low write strobe
module sram_port_arbiter #(
    parameter int LEN         = 32,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [LEN-1:0]    if_addr,
    output logic [LEN-1:0]    if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [LEN-1:0]    mem_addr,
    input  logic [LEN-1:0]    mem_wdata,
    output logic [LEN-1:0]    mem_rdata,
    output logic              mem_ready,
    output logic              if_freeze,
    output logic              mem_freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LEN-1:0]    sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [LEN-1:0]    sram_dq_in,
    output logic              sram_we_n
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             grant_mem;   // owner of the access in flight: 1 = MEM, 0 = IF
    logic             is_store;
    logic             mem_req;
    logic             take_mem;    // MEM would win if a grant happens this cycle
    logic             start;       // IDLE -> BUSY this cycle
    logic             last_beat;   // final BUSY cycle

    assign mem_req = mem_rd_en | mem_wr_en;

`ifdef ARB_FAIR_EN
    logic last_mem;  // port granted most recently: 1 = MEM, 0 = IF

    always_ff @(posedge clock) begin
        if (reset) begin
            last_mem <= 1'b0;
        end else if (start) begin
            last_mem <= take_mem;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        take_mem  = mem_req;
        last_beat = (state == BUSY) && (cnt == CNT_LAST);
`ifdef ARB_FAIR_EN
        // On a conflict the port that lost last time goes first.
        if (mem_req && if_req) begin
            take_mem = ~last_mem;
        end
`endif
        case (state)
            IDLE: begin
                if (mem_req || if_req) begin
                    state_nxt = BUSY;
                    start     = 1'b1;
                end
            end
            BUSY: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Always pass through IDLE so a waiting port is re-arbitrated fairly.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            grant_mem   <= 1'b0;
            is_store    <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            if_rdata    <= '0;
            mem_rdata   <= '0;
        end else begin
            state <= state_nxt;

            if (start) begin
                grant_mem <= take_mem;
                is_store  <= take_mem & mem_wr_en;
                sram_addr <= take_mem ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
                // Write strobe and pad drive span exactly the BUSY cycles of a store.
                if (take_mem && mem_wr_en) begin
                    sram_dq_out <= mem_wdata;
                    sram_we_n   <= 1'b0;
                    sram_dq_oe  <= 1'b1;
                end
            end

            if (state == BUSY) begin
                if (last_beat) begin
                    cnt        <= '0;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    if (!is_store) begin
                        if (grant_mem) begin
                            mem_rdata <= sram_dq_in;
                        end else begin
                            if_rdata <= sram_dq_in;
                        end
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign if_ready   = (state == DONE) & ~grant_mem;
    assign mem_ready  = (state == DONE) & grant_mem;
    assign if_freeze  = if_req & ~if_ready;
    assign mem_freeze = mem_req & ~mem_ready;

    // Byte-lane and out-of-range address bits are not used by a word-wide SRAM.
    logic addr_bits_unused;
    assign addr_bits_unused = ^{if_addr[LEN-1:ADDR_W+2], if_addr[1:0],
                                mem_addr[LEN-1:ADDR_W+2], mem_addr[1:0]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int WC = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        if_freeze;
    logic        mem_freeze;
    logic [17:0] sram_addr;
    logic [31:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_in;
    logic        sram_we_n;

    sram_port_arbiter #(.LEN(32), .ADDR_W(18), .WAIT_CYCLES(WC)) dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .if_freeze  (if_freeze),
        .mem_freeze (mem_freeze),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: a write lands only after the strobe has been low for WC consecutive edges.
    logic [31:0] sram [0:255];
    logic        tb_wr = 1'b0;
    logic [7:0]  tb_wa = 8'd0;
    logic [31:0] tb_wd = 32'd0;
    int          we_run = 0;
    logic        addr_hi_unused;

    assign sram_dq_in     = sram[sram_addr[7:0]];
    assign addr_hi_unused = ^sram_addr[17:8];

    always @(posedge clock) begin
        if (tb_wr) sram[tb_wa] <= tb_wd;
        if (!sram_we_n) begin
            if (we_run == WC - 1) sram[sram_addr[7:0]] <= sram_dq_out;
            we_run <= we_run + 1;
        end else begin
            we_run <= 0;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Scoreboard: one entry per expected ready pulse, in completion order.
    typedef struct {
        int          id;
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_ready(input int id, input bit is_mem, input bit chk_data,
                                input logic [31:0] data, input int lat);
        exp_t e;
        e.id       = id;
        e.is_mem   = is_mem;
        e.chk_data = chk_data;
        e.data     = data;
        e.cyc      = cyc + lat;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (if_ready || mem_ready) begin
            chk("ready_exclusive", 32'(if_ready & mem_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: if_ready=%0b mem_ready=%0b at cycle %0d, none expected",
                         if_ready, mem_ready, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("t%0d_ready_port", e.id), 32'(mem_ready), 32'(e.is_mem));
                chk($sformatf("t%0d_ready_cycle", e.id), 32'(cyc), 32'(e.cyc));
                if (e.chk_data)
                    chk($sformatf("t%0d_rdata", e.id), e.is_mem ? mem_rdata : if_rdata, e.data);
            end
        end
    end

    // Waits (bounded) for one port's ready, gathering pin activity, then drops that request.
    task automatic wait_done(input bit is_mem, input int budget, output int frz, output int we_lo,
                             output int oe_hi, output logic [17:0] addr_at_ready);
        bit got;
        got = 1'b0;
        frz = 0;
        we_lo = 0;
        oe_hi = 0;
        addr_at_ready = '0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clock);
            if (is_mem ? mem_freeze : if_freeze) frz++;
            if (!sram_we_n) we_lo++;
            if (sram_dq_oe) oe_hi++;
            if (is_mem ? mem_ready : if_ready) begin
                got = 1'b1;
                addr_at_ready = sram_addr;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no ready within %0d cycles", is_mem ? "mem" : "if", budget);
        end
        @(posedge clock);
        #1;
        if (is_mem) begin
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
        end else begin
            if_req = 1'b0;
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        tb_wr = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(posedge clock);
        #1;
        tb_wr = 1'b0;
    endtask

    int          f1, w1, o1, f2, w2, o2;
    logic [17:0] a1, a2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        poke(8'd4,  32'hDEAD_BEEF);
        poke(8'd2,  32'h0000_0000);
        poke(8'd8,  32'h1111_1111);
        poke(8'd9,  32'h2222_2222);
        poke(8'd10, 32'h3333_3333);
        poke(8'd11, 32'h4444_4444);
        poke(8'd12, 32'h5555_5555);
        poke(8'd32, 32'h0BAD_F00D);

        // Reset state
        @(negedge clock);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", sram_dq_out, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: single fetch
        expect_ready(1, 1'b0, 1'b1, 32'hDEAD_BEEF, 6);
        if_req = 1'b1;
        if_addr = 32'h0000_0010;
        wait_done(1'b0, 20, f1, w1, o1, a1);
        chk("t1_if_freeze_cycles", 32'(f1), 32'd6);
        chk("t1_sram_addr", 32'(a1), 32'd4);
        chk("t1_no_write", 32'(w1), 32'd0);

        // 2: store 0x1234_5678 to byte 0x40
        expect_ready(2, 1'b1, 1'b0, 32'd0, 6);
        mem_wr_en = 1'b1;
        mem_addr = 32'h0000_0040;
        mem_wdata = 32'h1234_5678;
        wait_done(1'b1, 20, f1, w1, o1, a1);
        chk("t2_mem_freeze_cycles", 32'(f1), 32'd6);
        chk("t2_we_low_cycles", 32'(w1), 32'd5);
        chk("t2_oe_high_cycles", 32'(o1), 32'd5);
        chk("t2_sram_addr", 32'(a1), 32'd16);
        chk("t2_model_word16", sram[16], 32'h1234_5678);

        // 3: load it back
        expect_ready(3, 1'b1, 1'b1, 32'h1234_5678, 6);
        mem_rd_en = 1'b1;
        mem_addr = 32'h0000_0040;
        wait_done(1'b1, 20, f1, w1, o1, a1);
        chk("t3_no_write", 32'(w1), 32'd0);

        // 4: reset during BUSY cycle 3 of a store: aborted, no ready pulse
        mem_wr_en = 1'b1;
        mem_addr = 32'h0000_0080;
        mem_wdata = 32'hFFFF_0000;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("t4_we_low_before_reset", 32'(sram_we_n), 32'd0);
        @(negedge clock);
        chk("t4_we_n_after_reset", 32'(sram_we_n), 32'd1);
        chk("t4_oe_after_reset", 32'(sram_dq_oe), 32'd0);
        @(posedge clock);
        #1;
        mem_wr_en = 1'b0;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("t4_model_word32_unchanged", sram[32], 32'h0BAD_F00D);
        expect_ready(4, 1'b1, 1'b1, 32'h0BAD_F00D, 6);
        mem_rd_en = 1'b1;
        mem_addr = 32'h0000_0080;
        wait_done(1'b1, 20, f1, w1, o1, a1);

        // 5: simultaneous requests right after reset: MEM first in both builds
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        expect_ready(5, 1'b1, 1'b1, 32'h2222_2222, 6);
        expect_ready(6, 1'b0, 1'b1, 32'h1111_1111, 13);
        if_req = 1'b1;
        if_addr = 32'h0000_0020;
        mem_rd_en = 1'b1;
        mem_addr = 32'h0000_0024;
        fork
            wait_done(1'b1, 30, f1, w1, o1, a1);
            wait_done(1'b0, 30, f2, w2, o2, a2);
        join
        chk("t5_mem_sram_addr", 32'(a1), 32'd9);
        chk("t5_if_sram_addr", 32'(a2), 32'd8);
        chk("t5_if_freeze_cycles", 32'(f2), 32'd13);

        // 6: MEM-only access so MEM is the most recent grant
        expect_ready(7, 1'b1, 1'b1, 32'h2222_2222, 6);
        mem_rd_en = 1'b1;
        mem_addr = 32'h0000_0024;
        wait_done(1'b1, 20, f1, w1, o1, a1);

        // 7: second conflict
`ifdef ARB_FAIR_EN
        expect_ready(8, 1'b0, 1'b1, 32'h3333_3333, 6);
        expect_ready(9, 1'b1, 1'b1, 32'h4444_4444, 13);
`else
        expect_ready(8, 1'b1, 1'b1, 32'h4444_4444, 6);
        expect_ready(9, 1'b0, 1'b1, 32'h3333_3333, 13);
`endif
        if_req = 1'b1;
        if_addr = 32'h0000_0028;
        mem_rd_en = 1'b1;
        mem_addr = 32'h0000_002C;
        fork
            wait_done(1'b1, 30, f1, w1, o1, a1);
            wait_done(1'b0, 30, f2, w2, o2, a2);
        join
        chk("t7_mem_sram_addr", 32'(a1), 32'd11);
        chk("t7_if_sram_addr", 32'(a2), 32'd10);

        // 8: fetch whose address changes and request drops in BUSY cycle 2
        expect_ready(10, 1'b0, 1'b1, 32'h5555_5555, 6);
        if_req = 1'b1;
        if_addr = 32'h0000_0030;
        @(posedge clock);
        #1;
        if_addr = 32'h0000_003C;
        @(posedge clock);
        #1;
        if_req = 1'b0;
        wait_done(1'b0, 20, f1, w1, o1, a1);
        chk("t8_latched_addr", 32'(a1), 32'd12);
        repeat (10) @(posedge clock);
        #1;

        // 9: rd and wr both high: a store, no load data returned
        expect_ready(11, 1'b1, 1'b0, 32'd0, 6);
        mem_rd_en = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr = 32'h0000_0008;
        mem_wdata = 32'h7777_8888;
        wait_done(1'b1, 20, f1, w1, o1, a1);
        chk("t9_we_low_cycles", 32'(w1), 32'd5);
        chk("t9_sram_addr", 32'(a1), 32'd2);
        chk("t9_mem_rdata_held", mem_rdata, 32'h4444_4444);
        chk("t9_model_word2", sram[2], 32'h7777_8888);
        expect_ready(12, 1'b1, 1'b1, 32'h7777_8888, 6);
        mem_rd_en = 1'b1;
        mem_addr = 32'h0000_0008;
        wait_done(1'b1, 20, f1, w1, o1, a1);

        repeat (10) @(posedge clock);
        #1;
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
